// File: rtl/hdlc_rx_pkg.sv
// hdlc_rx_pkg
// Shared definitions for the Hdlc Rx reader: register map of the Hdlc
// controller, bit positions inside the Rx status/control register, the
// reader's state encoding and a helper that decides whether a received
// frame must be discarded based on its status byte.
package hdlc_rx_pkg;

  // Hdlc controller register addresses
  localparam logic [2:0] ADDR_RX_SC   = 3'd2;
  localparam logic [2:0] ADDR_RX_BUFF = 3'd3;
  localparam logic [2:0] ADDR_RX_LEN  = 3'd4;

  // Bit positions inside Rx_SC
  localparam int SC_READY = 0;
  localparam int SC_DROP  = 1;
  localparam int SC_FERR  = 2;
  localparam int SC_ABORT = 3;
  localparam int SC_OVF   = 4;

  // Value written to Rx_SC to make the controller discard the frame
  localparam logic [7:0] RX_DROP_CMD = 8'(1 << SC_DROP);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_SC,
    ST_W_SC,
    ST_RD_LEN,
    ST_W_LEN,
    ST_RD_BYTE,
    ST_W_BYTE,
    ST_EMIT,
    ST_DROP,
    ST_ERR_BEAT,
    ST_GUARD
  } rx_state_t;

  // A frame is unusable when the controller flagged a framing error,
  // an abort sequence or a buffer overflow.
  function automatic logic sc_is_bad(input logic [7:0] sc);
    return sc[SC_FERR] | sc[SC_ABORT] | sc[SC_OVF];
  endfunction

endpackage

// File: rtl/hdlc_rx_reader_if.sv
// hdlc_rx_reader_if
// Bundles the two buses the Rx reader sits between:
//   - the Hdlc controller register port (Rx_Ready, Address, WriteEnable,
//     ReadEnable, WrData, RdData)
//   - the outgoing byte stream (M_Data, M_Valid, M_Ready, M_Sof, M_Eof,
//     M_Err)
// The master modport is the reader's view; the slave modport is the view
// of whatever models the controller and the stream sink.
interface hdlc_rx_reader_if;
  import hdlc_rx_pkg::*;

  logic       Rx_Ready;
  logic [2:0] Address;
  logic       WriteEnable;
  logic       ReadEnable;
  logic [7:0] WrData;
  logic [7:0] RdData;

  logic [7:0] M_Data;
  logic       M_Valid;
  logic       M_Ready;
  logic       M_Sof;
  logic       M_Eof;
  logic       M_Err;

  modport master (
    input  Rx_Ready, RdData, M_Ready,
    output Address, WriteEnable, ReadEnable, WrData,
    output M_Data, M_Valid, M_Sof, M_Eof, M_Err
  );

  modport slave (
    output Rx_Ready, RdData, M_Ready,
    input  Address, WriteEnable, ReadEnable, WrData,
    input  M_Data, M_Valid, M_Sof, M_Eof, M_Err
  );

endinterface

// File: rtl/hdlc_reg_rd.sv
// hdlc_reg_rd
// Single register read helper for the Hdlc controller port. The caller
// raises start for exactly one cycle together with the register address;
// that cycle is the read strobe on the bus. READ_LAT cycles later done is
// high for one cycle and data carries the byte the caller must register
// on that edge.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   start      one-cycle read request (already a registered pulse)
//   addr       register to read
//   rd_data    controller read data
//   read_en    read strobe to the controller
//   rd_addr    address to the controller, 0 when not strobing
//   done       read data valid this cycle
//   data       read byte, valid while done is high
module hdlc_reg_rd
  import hdlc_rx_pkg::*;
#(
  parameter int READ_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] addr,
  input  logic [7:0] rd_data,
  output logic       read_en,
  output logic [2:0] rd_addr,
  output logic       done,
  output logic [7:0] data
);

  localparam int LW = $clog2(READ_LAT + 1);

  logic [LW-1:0] wait_cnt;

  // The strobe is the caller's registered start pulse itself, so the
  // read costs no extra cycle; the counter then tracks the read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (start) begin
      wait_cnt <= LW'(READ_LAT);
    end else if (wait_cnt != '0) begin
      wait_cnt <= wait_cnt - LW'(1);
    end
  end

  assign read_en = start;
  assign rd_addr = start ? addr : 3'd0;
  assign done    = (wait_cnt == LW'(1));
  assign data    = rd_data;

endmodule

// File: rtl/hdlc_rx_reader.sv
// hdlc_rx_reader
// Pulls received frames out of the Hdlc controller and replays them as a
// valid/ready byte stream. For every frame it reads Rx_SC, then Rx_Len,
// then Rx_Buff once per byte. Frames with a bad status or an illegal
// length are dropped by writing Rx_Drop and reported as one error beat.
// Ports:
//   Clk, Rst    clock and synchronous active-high reset
//   bus         controller register port and outgoing stream (master)
//   Frame_Cnt   good frames delivered (wraps)
//   Err_Cnt     frames discarded (wraps)
module hdlc_rx_reader
  import hdlc_rx_pkg::*;
#(
  parameter int READ_LAT = 1,
  parameter int MAX_LEN  = 126,
  parameter int GUARD    = 2,
  parameter int CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  hdlc_rx_reader_if.master bus,
  output logic [CNT_W-1:0] Frame_Cnt,
  output logic [CNT_W-1:0] Err_Cnt
);

  localparam int GW = (GUARD < 2) ? 1 : $clog2(GUARD + 1);

  rx_state_t     state;
  logic          rd_start;
  logic [2:0]    rd_sel;
  logic          rd_en;
  logic          rd_done;
  logic [2:0]    rd_addr;
  logic [7:0]    rd_byte;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic [7:0]    sc;
  logic [7:0]    len;
  logic [7:0]    cnt;
  logic [7:0]    m_data;
  logic          m_valid;
  logic          m_sof;
  logic          m_eof;
  logic          m_err;
  logic [GW-1:0] guard_cnt;

  hdlc_reg_rd #(
    .READ_LAT(READ_LAT)
  ) u_reg_rd (
    .clk    (Clk),
    .rst    (Rst),
    .start  (rd_start),
    .addr   (rd_sel),
    .rd_data(bus.RdData),
    .read_en(rd_en),
    .rd_addr(rd_addr),
    .done   (rd_done),
    .data   (rd_byte)
  );

  // Main sequencer. Strobes are set on the transition into RD_* / DROP
  // and cleared by default one cycle later, so each register access is a
  // single-cycle pulse. Stream outputs are loaded on the edge the byte
  // arrives, giving 2+READ_LAT cycles per byte with the sink always ready.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= ST_IDLE;
      rd_start  <= 1'b0;
      rd_sel    <= 3'd0;
      wr_en     <= 1'b0;
      wr_data   <= 8'd0;
      sc        <= 8'd0;
      len       <= 8'd0;
      cnt       <= 8'd0;
      m_data    <= 8'd0;
      m_valid   <= 1'b0;
      m_sof     <= 1'b0;
      m_eof     <= 1'b0;
      m_err     <= 1'b0;
      guard_cnt <= '0;
      Frame_Cnt <= '0;
      Err_Cnt   <= '0;
    end else begin
      rd_start <= 1'b0;
      rd_sel   <= 3'd0;
      wr_en    <= 1'b0;
      wr_data  <= 8'd0;
      case (state)
        ST_IDLE: begin
          if (guard_cnt == '0 && bus.Rx_Ready) begin
            state    <= ST_RD_SC;
            rd_start <= 1'b1;
            rd_sel   <= ADDR_RX_SC;
          end
        end
        ST_RD_SC: state <= ST_W_SC;
        ST_W_SC: begin
          if (rd_done) begin
            sc <= rd_byte;
            if (sc_is_bad(rd_byte)) begin
              state   <= ST_DROP;
              wr_en   <= 1'b1;
              wr_data <= RX_DROP_CMD;
            end else begin
              state    <= ST_RD_LEN;
              rd_start <= 1'b1;
              rd_sel   <= ADDR_RX_LEN;
            end
          end
        end
        ST_RD_LEN: state <= ST_W_LEN;
        ST_W_LEN: begin
          if (rd_done) begin
            len <= rd_byte;
            if (rd_byte == 8'd0 || int'(rd_byte) > MAX_LEN) begin
              state   <= ST_DROP;
              wr_en   <= 1'b1;
              wr_data <= RX_DROP_CMD;
            end else begin
              cnt      <= 8'd0;
              state    <= ST_RD_BYTE;
              rd_start <= 1'b1;
              rd_sel   <= ADDR_RX_BUFF;
            end
          end
        end
        ST_RD_BYTE: state <= ST_W_BYTE;
        ST_W_BYTE: begin
          if (rd_done) begin
            m_data  <= rd_byte;
            m_valid <= 1'b1;
            m_sof   <= (cnt == 8'd0);
            m_eof   <= (cnt == len - 8'd1);
            state   <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (bus.M_Ready) begin
            m_valid <= 1'b0;
            m_sof   <= 1'b0;
            m_eof   <= 1'b0;
            m_data  <= 8'd0;
            cnt     <= cnt + 8'd1;
            if (m_eof) begin
              Frame_Cnt <= Frame_Cnt + CNT_W'(1);
              guard_cnt <= GW'(GUARD);
              state     <= ST_GUARD;
            end else begin
              state    <= ST_RD_BYTE;
              rd_start <= 1'b1;
              rd_sel   <= ADDR_RX_BUFF;
            end
          end
        end
        ST_DROP: begin
          Err_Cnt <= Err_Cnt + CNT_W'(1);
          m_data  <= sc;
          m_valid <= 1'b1;
          m_sof   <= 1'b1;
          m_eof   <= 1'b1;
          m_err   <= 1'b1;
          state   <= ST_ERR_BEAT;
        end
        ST_ERR_BEAT: begin
          if (bus.M_Ready) begin
            m_data    <= 8'd0;
            m_valid   <= 1'b0;
            m_sof     <= 1'b0;
            m_eof     <= 1'b0;
            m_err     <= 1'b0;
            guard_cnt <= GW'(GUARD);
            state     <= ST_GUARD;
          end
        end
        // Rx_Ready stays high briefly after the last read; sitting here
        // for GUARD cycles keeps IDLE from mistaking it for a new frame.
        ST_GUARD: begin
          if (guard_cnt <= GW'(1)) begin
            guard_cnt <= '0;
            state     <= ST_IDLE;
          end else begin
            guard_cnt <= guard_cnt - GW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ReadEnable  = rd_en;
  assign bus.WriteEnable = wr_en;
  assign bus.Address     = wr_en ? ADDR_RX_SC : rd_addr;
  assign bus.WrData      = wr_data;
  assign bus.M_Data      = m_data;
  assign bus.M_Valid     = m_valid;
  assign bus.M_Sof       = m_sof;
  assign bus.M_Eof       = m_eof;
  assign bus.M_Err       = m_err;

endmodule
